// File: rtl/trap_pkg.sv
// Shared cause codes and encodings for the trap/MRET sequencer.
// Interrupt cause codes are the machine-mode mcause values without the interrupt bit.
package trap_pkg;

   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_REDIRECT = 2'd2
   } trap_state_e;

   typedef enum logic [1:0] {
      REQ_EXC  = 2'd0,
      REQ_INT  = 2'd1,
      REQ_MRET = 2'd2
   } req_kind_e;

endpackage

// File: rtl/trap_irq_prioritizer.sv
// Combinational machine-interrupt enable and priority resolution.
// Software interrupt (MSI) wins over timer interrupt (MTI).
module trap_irq_prioritizer
   import trap_pkg::*;
(
   input  logic       mstatus_mie,
   input  logic       mie_msie,
   input  logic       mie_mtie,
   input  logic       mip_msip,
   input  logic       timer_irq,
   output logic       irq_valid,
   output logic [3:0] irq_cause
);

   logic msi_pend;
   logic mti_pend;

   always_comb begin
      msi_pend  = mstatus_mie & mip_msip & mie_msie;
      mti_pend  = mstatus_mie & timer_irq & mie_mtie;
      irq_valid = msi_pend | mti_pend;
      irq_cause = 4'd0;
      if (msi_pend) begin
         irq_cause = CAUSE_MSI;
      end else if (mti_pend) begin
         irq_cause = CAUSE_MTI;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / MRET sequencer: IDLE -> COMMIT (csr strobe) -> REDIRECT (fetch handshake).
// redirect_valid/redirect_pc form a valid/ready pair: pc is held while valid is high and not ready.
module trap_sequencer
   import trap_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int VECTORED = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exc_valid,
   input  logic [3:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            retire_valid,
   input  logic [XLEN-1:0] retire_next_pc,
   input  logic            mret_req,
   input  logic            mstatus_mie,
   input  logic            mie_msie,
   input  logic            mie_mtie,
   input  logic            mip_msip,
   input  logic            timer_irq,
   input  logic [XLEN-1:0] mtvec_base,
   input  logic [XLEN-1:0] mepc_in,
   output logic            trap_taken,
   output logic [XLEN-1:0] trap_pc,
   output logic [3:0]      trap_cause,
   output logic [XLEN-1:0] trap_value,
   output logic            is_interrupt,
   output logic            mret,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready,
   output logic            core_stall,
   output trap_state_e     dbg_state
);

   trap_state_e     state_q, state_d;
   req_kind_e       kind_q, kind_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [3:0]      cause_q, cause_d;
   logic [XLEN-1:0] tval_q, tval_d;

   logic            irq_valid;
   logic [3:0]      irq_cause;

   trap_irq_prioritizer u_prio (
      .mstatus_mie (mstatus_mie),
      .mie_msie    (mie_msie),
      .mie_mtie    (mie_mtie),
      .mip_msip    (mip_msip),
      .timer_irq   (timer_irq),
      .irq_valid   (irq_valid),
      .irq_cause   (irq_cause)
   );

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      tval_d  = tval_q;
      case (state_q)
         ST_IDLE: begin
            if (exc_valid) begin
               state_d = ST_COMMIT;
               kind_d  = REQ_EXC;
               pc_d    = exc_pc;
               cause_d = exc_cause;
               tval_d  = exc_tval;
            end else if (mret_req) begin
               state_d = ST_COMMIT;
               kind_d  = REQ_MRET;
               pc_d    = '0;
               cause_d = 4'd0;
               tval_d  = '0;
            end else if (retire_valid && irq_valid) begin
               state_d = ST_COMMIT;
               kind_d  = REQ_INT;
               pc_d    = retire_next_pc;
               cause_d = irq_cause;
               tval_d  = '0;
            end
         end
         ST_COMMIT: state_d = ST_REDIRECT;
         ST_REDIRECT: begin
            if (redirect_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         kind_q  <= REQ_EXC;
         pc_q    <= '0;
         cause_q <= 4'd0;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
      end
   end

   // Redirect target is read from csr_file live in REDIRECT so the COMMIT-cycle write is seen.
   always_comb begin
      trap_taken     = (state_q == ST_COMMIT) && (kind_q != REQ_MRET);
      mret           = (state_q == ST_COMMIT) && (kind_q == REQ_MRET);
      trap_pc        = pc_q;
      trap_cause     = cause_q;
      trap_value     = tval_q;
      is_interrupt   = (kind_q == REQ_INT);
      core_stall     = (state_q != ST_IDLE);
      redirect_valid = (state_q == ST_REDIRECT);
      redirect_pc    = '0;
      if (state_q == ST_REDIRECT) begin
         if (kind_q == REQ_MRET) begin
            redirect_pc = mepc_in;
         end else if ((VECTORED != 0) && (kind_q == REQ_INT)) begin
            redirect_pc = mtvec_base + {{(XLEN-6){1'b0}}, cause_q, 2'b00};
         end else begin
            redirect_pc = mtvec_base;
         end
      end
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a non-vectored and a vectored instance share stimulus;
// directed table, hand-written corner sequences, then random transactions against a reference model.
module tb_trap_sequencer;

   typedef struct {
      logic        exc_valid;
      logic [3:0]  exc_cause;
      logic [31:0] exc_pc;
      logic [31:0] exc_tval;
      logic        retire_valid;
      logic [31:0] next_pc;
      logic        mret_req;
      logic        mie;
      logic        msie;
      logic        mtie;
      logic        msip;
      logic        timer;
      logic [31:0] mtvec;
      logic [31:0] mepc;
      logic        exp_taken;
      logic        exp_mret;
      logic [3:0]  exp_cause;
      logic [31:0] exp_pc;
      logic [31:0] exp_val;
      logic        exp_int;
      logic [31:0] exp_redir;
      logic [31:0] exp_redir_v;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        exc_valid = 1'b0;
   logic [3:0]  exc_cause = '0;
   logic [31:0] exc_pc = '0;
   logic [31:0] exc_tval = '0;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_next_pc = '0;
   logic        mret_req = 1'b0;
   logic        mstatus_mie = 1'b0;
   logic        mie_msie = 1'b0;
   logic        mie_mtie = 1'b0;
   logic        mip_msip = 1'b0;
   logic        timer_irq = 1'b0;
   logic [31:0] mtvec_base = '0;
   logic [31:0] mepc_in = '0;
   logic        redirect_ready = 1'b0;

   logic        trap_taken     [2];
   logic [31:0] trap_pc        [2];
   logic [3:0]  trap_cause     [2];
   logic [31:0] trap_value     [2];
   logic        is_interrupt   [2];
   logic        mret           [2];
   logic        redirect_valid [2];
   logic [31:0] redirect_pc    [2];
   logic        core_stall     [2];
   logic [1:0]  dbg_state      [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   trap_sequencer #(.XLEN(32), .VECTORED(0)) u_dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .retire_valid(retire_valid), .retire_next_pc(retire_next_pc), .mret_req(mret_req),
      .mstatus_mie(mstatus_mie), .mie_msie(mie_msie), .mie_mtie(mie_mtie),
      .mip_msip(mip_msip), .timer_irq(timer_irq), .mtvec_base(mtvec_base), .mepc_in(mepc_in),
      .trap_taken(trap_taken[0]), .trap_pc(trap_pc[0]), .trap_cause(trap_cause[0]),
      .trap_value(trap_value[0]), .is_interrupt(is_interrupt[0]), .mret(mret[0]),
      .redirect_valid(redirect_valid[0]), .redirect_pc(redirect_pc[0]),
      .redirect_ready(redirect_ready), .core_stall(core_stall[0]), .dbg_state(dbg_state[0])
   );

   trap_sequencer #(.XLEN(32), .VECTORED(1)) u_dut_v (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .retire_valid(retire_valid), .retire_next_pc(retire_next_pc), .mret_req(mret_req),
      .mstatus_mie(mstatus_mie), .mie_msie(mie_msie), .mie_mtie(mie_mtie),
      .mip_msip(mip_msip), .timer_irq(timer_irq), .mtvec_base(mtvec_base), .mepc_in(mepc_in),
      .trap_taken(trap_taken[1]), .trap_pc(trap_pc[1]), .trap_cause(trap_cause[1]),
      .trap_value(trap_value[1]), .is_interrupt(is_interrupt[1]), .mret(mret[1]),
      .redirect_valid(redirect_valid[1]), .redirect_pc(redirect_pc[1]),
      .redirect_ready(redirect_ready), .core_stall(core_stall[1]), .dbg_state(dbg_state[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk_in(logic ev, logic [3:0] ec, logic [31:0] ep, logic [31:0] et,
                                  logic rv, logic [31:0] np, logic mr, logic mie, logic msie,
                                  logic mtie, logic msip, logic tmr, logic [31:0] mtv,
                                  logic [31:0] mepc);
      vec_t v;
      v.exc_valid = ev;  v.exc_cause = ec;  v.exc_pc = ep;  v.exc_tval = et;
      v.retire_valid = rv;  v.next_pc = np;  v.mret_req = mr;
      v.mie = mie;  v.msie = msie;  v.mtie = mtie;  v.msip = msip;  v.timer = tmr;
      v.mtvec = mtv;  v.mepc = mepc;
      v.exp_taken = 0;  v.exp_mret = 0;  v.exp_cause = 0;  v.exp_pc = 0;  v.exp_val = 0;
      v.exp_int = 0;  v.exp_redir = 0;  v.exp_redir_v = 0;
      return v;
   endfunction

   function automatic vec_t with_exp(vec_t vi, logic tk, logic mr, logic [3:0] c, logic [31:0] pc,
                                     logic [31:0] val, logic isi, logic [31:0] rd,
                                     logic [31:0] rdv);
      vec_t v = vi;
      v.exp_taken = tk;  v.exp_mret = mr;  v.exp_cause = c;  v.exp_pc = pc;  v.exp_val = val;
      v.exp_int = isi;  v.exp_redir = rd;  v.exp_redir_v = rdv;
      return v;
   endfunction

   // Reference: what a single request cycle in IDLE should produce, from the arbitration rules.
   function automatic vec_t model(vec_t vi);
      vec_t v = vi;
      bit msi = vi.retire_valid && vi.mie && vi.msip && vi.msie;
      bit mti = vi.retire_valid && vi.mie && vi.timer && vi.mtie;
      int code;
      v = with_exp(vi, 0, 0, 0, 0, 0, 0, 0, 0);
      if (vi.exc_valid) begin
         v = with_exp(vi, 1, 0, vi.exc_cause, vi.exc_pc, vi.exc_tval, 0, vi.mtvec, vi.mtvec);
      end else if (vi.mret_req) begin
         v = with_exp(vi, 0, 1, 0, 0, 0, 0, vi.mepc, vi.mepc);
      end else if (msi || mti) begin
         code = msi ? 3 : 7;
         v = with_exp(vi, 1, 0, 4'(code), vi.next_pc, 0, 1, vi.mtvec,
                      vi.mtvec + 32'(4 * code));
      end
      return v;
   endfunction

   task automatic drive(input vec_t v);
      exc_valid = v.exc_valid;  exc_cause = v.exc_cause;  exc_pc = v.exc_pc;
      exc_tval = v.exc_tval;  retire_valid = v.retire_valid;  retire_next_pc = v.next_pc;
      mret_req = v.mret_req;  mstatus_mie = v.mie;  mie_msie = v.msie;  mie_mtie = v.mtie;
      mip_msip = v.msip;  timer_irq = v.timer;  mtvec_base = v.mtvec;  mepc_in = v.mepc;
   endtask

   task automatic clear_reqs();
      exc_valid = 1'b0;
      mret_req = 1'b0;
      retire_valid = 1'b0;
   endtask

   // One request cycle from IDLE, then COMMIT, REDIRECT held for delay extra cycles, and return.
   task automatic run_txn(input vec_t v, input int delay, input bit junk);
      bit has_req = v.exp_taken || v.exp_mret;
      @(negedge clk);
      drive(v);
      redirect_ready = 1'b0;
      @(negedge clk);
      clear_reqs();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("commit_taken[%0d]", i), 32'(trap_taken[i]), 32'(v.exp_taken));
         check($sformatf("commit_mret[%0d]", i), 32'(mret[i]), 32'(v.exp_mret));
         check($sformatf("commit_stall[%0d]", i), 32'(core_stall[i]), 32'(has_req));
         check($sformatf("commit_rvalid[%0d]", i), 32'(redirect_valid[i]), 32'd0);
         if (v.exp_taken) begin
            check($sformatf("trap_cause[%0d]", i), 32'(trap_cause[i]), 32'(v.exp_cause));
            check($sformatf("trap_pc[%0d]", i), trap_pc[i], v.exp_pc);
            check($sformatf("trap_value[%0d]", i), trap_value[i], v.exp_val);
            check($sformatf("is_interrupt[%0d]", i), 32'(is_interrupt[i]), 32'(v.exp_int));
         end
      end
      if (!has_req) return;
      if (junk) begin
         exc_valid = 1'($urandom_range(0, 1));
         mret_req = 1'($urandom_range(0, 1));
         retire_valid = 1'b1;
         exc_pc = $urandom;
         retire_next_pc = $urandom;
         mip_msip = 1'($urandom_range(0, 1));
         timer_irq = 1'($urandom_range(0, 1));
      end
      for (int d = 0; d <= delay; d++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            check($sformatf("redir_valid[%0d]", i), 32'(redirect_valid[i]), 32'd1);
            check($sformatf("redir_pc[%0d]", i), redirect_pc[i],
                  (i == 0) ? v.exp_redir : v.exp_redir_v);
            check($sformatf("redir_stall[%0d]", i), 32'(core_stall[i]), 32'd1);
            check($sformatf("redir_no_strobe[%0d]", i), 32'(trap_taken[i] | mret[i]), 32'd0);
         end
         if (d == delay) begin
            redirect_ready = 1'b1;
            clear_reqs();
         end
      end
      @(negedge clk);
      redirect_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("done_stall[%0d]", i), 32'(core_stall[i]), 32'd0);
         check($sformatf("done_rvalid[%0d]", i), 32'(redirect_valid[i]), 32'd0);
         check($sformatf("done_strobe[%0d]", i), 32'(trap_taken[i] | mret[i]), 32'd0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_taken[%0d]", tag, i), 32'(trap_taken[i]), 32'd0);
         check($sformatf("%s_mret[%0d]", tag, i), 32'(mret[i]), 32'd0);
         check($sformatf("%s_pc[%0d]", tag, i), trap_pc[i], 32'd0);
         check($sformatf("%s_cause[%0d]", tag, i), 32'(trap_cause[i]), 32'd0);
         check($sformatf("%s_value[%0d]", tag, i), trap_value[i], 32'd0);
         check($sformatf("%s_int[%0d]", tag, i), 32'(is_interrupt[i]), 32'd0);
         check($sformatf("%s_rvalid[%0d]", tag, i), 32'(redirect_valid[i]), 32'd0);
         check($sformatf("%s_rpc[%0d]", tag, i), redirect_pc[i], 32'd0);
         check($sformatf("%s_stall[%0d]", tag, i), 32'(core_stall[i]), 32'd0);
      end
   endtask

   vec_t tbl [12];
   vec_t rv;

   initial begin
      tbl[0]  = with_exp(mk_in(1, 2, 32'h100, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 32'h800, 0),
                         1, 0, 2, 32'h100, 32'hDEAD, 0, 32'h800, 32'h800);
      tbl[1]  = with_exp(mk_in(0, 0, 0, 0, 1, 32'h204, 0, 1, 1, 1, 1, 1, 32'h800, 0),
                         1, 0, 3, 32'h204, 0, 1, 32'h800, 32'h80C);
      tbl[2]  = with_exp(mk_in(0, 0, 0, 0, 1, 32'h40, 0, 1, 0, 1, 0, 1, 32'h1000, 0),
                         1, 0, 7, 32'h40, 0, 1, 32'h1000, 32'h101C);
      tbl[3]  = with_exp(mk_in(0, 0, 0, 0, 1, 32'h40, 0, 0, 1, 1, 1, 1, 32'h1000, 0),
                         0, 0, 0, 0, 0, 0, 0, 0);
      tbl[4]  = with_exp(mk_in(1, 5, 32'h50, 32'h77, 1, 32'h60, 1, 1, 1, 1, 1, 1, 32'h800, 32'h300),
                         1, 0, 5, 32'h50, 32'h77, 0, 32'h800, 32'h800);
      tbl[5]  = with_exp(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h800, 32'h300),
                         0, 1, 0, 0, 0, 0, 32'h300, 32'h300);
      tbl[6]  = with_exp(mk_in(0, 0, 0, 0, 1, 32'h88, 1, 1, 1, 1, 1, 1, 32'h800, 32'h444),
                         0, 1, 0, 0, 0, 0, 32'h444, 32'h444);
      tbl[7]  = with_exp(mk_in(0, 0, 0, 0, 0, 32'h90, 0, 1, 1, 1, 1, 1, 32'h800, 0),
                         0, 0, 0, 0, 0, 0, 0, 0);
      tbl[8]  = with_exp(mk_in(0, 0, 0, 0, 1, 32'hA0, 0, 1, 0, 1, 1, 1, 32'h2000, 0),
                         1, 0, 7, 32'hA0, 0, 1, 32'h2000, 32'h201C);
      tbl[9]  = with_exp(mk_in(0, 0, 0, 0, 1, 32'hB0, 0, 1, 0, 1, 0, 1, 32'hFFFF_FFF0, 0),
                         1, 0, 7, 32'hB0, 0, 1, 32'hFFFF_FFF0, 32'h0000_000C);
      tbl[10] = with_exp(mk_in(0, 0, 0, 0, 1, 32'hC4, 0, 1, 1, 0, 1, 1, 32'h3000, 0),
                         1, 0, 3, 32'hC4, 0, 1, 32'h3000, 32'h300C);
      tbl[11] = with_exp(mk_in(1, 11, 32'hC8, 32'h0, 1, 32'hCC, 0, 1, 1, 1, 1, 1, 32'h3000, 0),
                         1, 0, 11, 32'hC8, 0, 0, 32'h3000, 32'h3000);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      for (int k = 0; k < 12; k++) begin
         run_txn(tbl[k], 0, 1'b0);
      end

      // Fetch back-pressure: redirect held five cycles with junk requests ignored meanwhile
      run_txn(tbl[0], 5, 1'b1);
      run_txn(tbl[5], 5, 1'b1);

      // Reset during COMMIT aborts the sequence
      @(negedge clk);
      drive(tbl[1]);
      @(negedge clk);
      clear_reqs();
      check("pre_reset_taken", 32'(trap_taken[0]), 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      redirect_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            check($sformatf("post_rst_rvalid[%0d]", i), 32'(redirect_valid[i]), 32'd0);
            check($sformatf("post_rst_strobe[%0d]", i), 32'(trap_taken[i] | mret[i]), 32'd0);
            check($sformatf("post_rst_stall[%0d]", i), 32'(core_stall[i]), 32'd0);
         end
      end
      redirect_ready = 1'b0;

      // Random transactions against the reference model
      for (int k = 0; k < 200; k++) begin
         rv = mk_in($urandom_range(0, 3) == 0, 4'($urandom_range(0, 11)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, $urandom);
         rv = model(rv);
         run_txn(rv, int'($urandom_range(0, 3)), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
